// File: rtl/chip8_mem_pkg.sv
// chip8_mem_pkg: shared widths, requester ids and one-hot grant codes for the memory arbiter
package chip8_mem_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_VGA_MAX_BURST = 4;
  typedef enum logic [1:0] {REQ_VGA = 2'd0, REQ_CPU = 2'd1, REQ_GPU = 2'd2} req_id_t;
  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_VGA = 3'b001;
  localparam logic [2:0] GNT_CPU = 3'b010;
  localparam logic [2:0] GNT_GPU = 3'b100;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; ptr names the side that wins a tie (0=CPU, 1=GPU)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] el,
  output logic [1:0] gnt
);
  logic ptr;
  assign gnt = !en ? 2'b00 : &el ? (ptr ? 2'b10 : 2'b01) : el;
  // after a grant the tie goes to the side that was not served
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM shared by VGA (priority, burst-limited) and CPU/GPU (round-robin)
module mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int VGA_MAX_BURST = DEF_VGA_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic              gpu_ack,
  output logic [DATA_W-1:0] gpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        grant
);
  localparam logic [3:0] MAX_BURST = 4'(VGA_MAX_BURST);
  logic [3:0] burst_cnt;
  logic vga_el, cpu_el, gpu_el, cg_el, vga_sel, cpu_rd, gpu_rd;
  logic [1:0] rr_gnt;
  logic [DATA_W-1:0] vga_q, cpu_q, gpu_q;
  // a port being acked this cycle cannot be granted again until its next cycle
  assign vga_el = vga_req & ~vga_ack;
  assign cpu_el = cpu_req & ~cpu_ack;
  assign gpu_el = gpu_req & ~gpu_ack;
  assign cg_el = cpu_el | gpu_el;
  assign vga_sel = rst_n & vga_el & ((burst_cnt < MAX_BURST) | ~cg_el);
  rr_arb2 u_rr (
    .clk(clk),
    .rst_n(rst_n),
    .en(rst_n & ~vga_sel),
    .el({gpu_el, cpu_el}),
    .gnt(rr_gnt)
  );
  assign grant = {rr_gnt, vga_sel};
  assign ram_en = |grant;
  assign ram_we = grant[REQ_CPU] ? cpu_we : grant[REQ_GPU] ? gpu_we : 1'b0;
  assign ram_addr = grant[REQ_CPU] ? cpu_addr : grant[REQ_GPU] ? gpu_addr :
                    grant[REQ_VGA] ? vga_addr : '0;
  assign ram_wdata = grant[REQ_CPU] ? cpu_wdata : grant[REQ_GPU] ? gpu_wdata : '0;
  // read data arrives from the RAM during the ack cycle; pass it through, then hold it
  assign vga_rdata = vga_ack ? ram_rdata : vga_q;
  assign cpu_rdata = (cpu_ack & cpu_rd) ? ram_rdata : cpu_q;
  assign gpu_rdata = (gpu_ack & gpu_rd) ? ram_rdata : gpu_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vga_ack <= 1'b0;
      cpu_ack <= 1'b0;
      gpu_ack <= 1'b0;
      cpu_rd <= 1'b0;
      gpu_rd <= 1'b0;
      vga_q <= '0;
      cpu_q <= '0;
      gpu_q <= '0;
      burst_cnt <= 4'd0;
    end else begin
      vga_ack <= grant[REQ_VGA];
      cpu_ack <= grant[REQ_CPU];
      gpu_ack <= grant[REQ_GPU];
      cpu_rd <= grant[REQ_CPU] & ~cpu_we;
      gpu_rd <= grant[REQ_GPU] & ~gpu_we;
      vga_q <= vga_rdata;
      cpu_q <= cpu_rdata;
      gpu_q <= gpu_rdata;
      burst_cnt <= (|rr_gnt || !(cpu_req || gpu_req)) ? 4'd0 :
                   (vga_sel && cg_el && burst_cnt != 4'hf) ? burst_cnt + 4'd1 : burst_cnt;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and random traffic against a rule-level model
module tb_mem_arbiter;
  import chip8_mem_pkg::*;
  localparam int MAXB = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic vga_req = 1'b0, cpu_req = 1'b0, gpu_req = 1'b0, cpu_we = 1'b0, gpu_we = 1'b0;
  logic [11:0] vga_addr = '0, cpu_addr = '0, gpu_addr = '0;
  logic [7:0] cpu_wdata = '0, gpu_wdata = '0;
  logic vga_ack, cpu_ack, gpu_ack, ram_en, ram_we;
  logic [7:0] vga_rdata, cpu_rdata, gpu_rdata, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic [11:0] ram_addr;
  logic [2:0] grant;
  logic [7:0] ram [4096] = '{default: 8'h00};
  int tests = 0, fails = 0;
  logic [7:0] shadow [4096];
  int burst, rr;
  logic [2:0] m_ack, m_rd;
  logic [7:0] m_val [3], m_hold [3];
  logic [2:0] last_g;
  logic [12:0] last_wa;
  typedef struct {
    logic [2:0] req;
    logic cw, gw;
    logic [11:0] va, ca, ga;
    logic [7:0] cd, gd;
    logic [2:0] eg;
    logic ewe;
    logic [11:0] eaddr;
  } vec_t;
  vec_t tv [8];
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(12), .DATA_W(8), .VGA_MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
    .gpu_ack(gpu_ack), .gpu_rdata(gpu_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .grant(grant)
  );
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else ram_rdata <= ram[ram_addr];
    end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_ack = '0;
    m_rd = '0;
    burst = 0;
    rr = 0;
    for (int p = 0; p < 3; p++) m_hold[p] = '0;
  endtask
  task automatic drop_all();
    vga_req = 1'b0;
    cpu_req = 1'b0;
    gpu_req = 1'b0;
  endtask
  // called just after a falling edge with inputs already driven; returns at the next falling edge
  task automatic step();
    logic [2:0] el, g;
    logic cg;
    logic [7:0] rd_now [3];
    #2;
    rd_now = '{vga_rdata, cpu_rdata, gpu_rdata};
    check("ack", {gpu_ack, cpu_ack, vga_ack}, m_ack);
    for (int p = 0; p < 3; p++)
      if (m_ack[p]) begin
        if (m_rd[p]) m_hold[p] = m_val[p];
        check($sformatf("rdata%0d", p), rd_now[p], m_hold[p]);
      end
    el = {gpu_req, cpu_req, vga_req} & ~m_ack;
    cg = el[1] | el[2];
    if (el[0] && (burst < MAXB || !cg)) g = GNT_VGA;
    else if (el[1] && el[2]) g = (rr == 0) ? GNT_CPU : GNT_GPU;
    else g = el & 3'b110;
    last_g = grant;
    last_wa = {ram_we, ram_addr};
    check("grant", grant, g);
    check("ram_en", ram_en, |g);
    if (g == GNT_VGA) check("vga_port", {ram_we, ram_addr}, {1'b0, vga_addr});
    if (g == GNT_CPU) check("cpu_port", {ram_we, ram_addr, ram_we ? ram_wdata : 8'h0},
                            {cpu_we, cpu_addr, cpu_we ? cpu_wdata : 8'h0});
    if (g == GNT_GPU) check("gpu_port", {ram_we, ram_addr, ram_we ? ram_wdata : 8'h0},
                            {gpu_we, gpu_addr, gpu_we ? gpu_wdata : 8'h0});
    m_rd = '0;
    if (g[0]) begin m_rd[0] = 1'b1; m_val[0] = shadow[vga_addr]; end
    if (g[1]) begin
      if (cpu_we) shadow[cpu_addr] = cpu_wdata;
      else begin m_rd[1] = 1'b1; m_val[1] = shadow[cpu_addr]; end
    end
    if (g[2]) begin
      if (gpu_we) shadow[gpu_addr] = gpu_wdata;
      else begin m_rd[2] = 1'b1; m_val[2] = shadow[gpu_addr]; end
    end
    m_ack = g;
    if (g[1] || g[2] || !(cpu_req || gpu_req)) burst = 0;
    else if (g[0] && cg) burst = (burst < 15) ? burst + 1 : 15;
    if (g[1]) rr = 1;
    else if (g[2]) rr = 0;
    @(negedge clk);
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    drop_all();
    cpu_we = 1'b0;
    gpu_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ctl", {vga_ack, cpu_ack, gpu_ack, grant, ram_en, ram_we}, '0);
    check("rst_data", {vga_rdata, cpu_rdata, gpu_rdata, ram_addr, ram_wdata}, '0);
    rst_n = 1'b1;
    model_reset();
  endtask
  function automatic logic [11:0] rnd_addr();
    int k;
    k = $urandom_range(0, 5);
    return (k == 0) ? 12'h000 : (k == 1) ? 12'hFFF : (k == 2) ? 12'h200 : 12'($urandom_range(0, 7));
  endfunction
  initial begin
    bit pv, pc, pg;
    for (int i = 0; i < 4096; i++) shadow[i] = '0;
    model_reset();
    tv[0] = '{3'b000, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, GNT_NONE, 1'b0, 12'h000};
    tv[1] = '{3'b001, 1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, GNT_VGA, 1'b0, 12'h000};
    tv[2] = '{3'b010, 1'b0, 1'b0, 12'h000, 12'h200, 12'h000, 8'h00, 8'h00, GNT_CPU, 1'b0, 12'h200};
    tv[3] = '{3'b010, 1'b1, 1'b0, 12'h000, 12'h201, 12'h000, 8'h3C, 8'h00, GNT_CPU, 1'b1, 12'h201};
    tv[4] = '{3'b100, 1'b0, 1'b1, 12'h000, 12'h000, 12'hFFF, 8'h00, 8'h5A, GNT_GPU, 1'b1, 12'hFFF};
    tv[5] = '{3'b110, 1'b0, 1'b0, 12'h000, 12'h010, 12'h020, 8'h00, 8'h00, GNT_CPU, 1'b0, 12'h010};
    tv[6] = '{3'b111, 1'b0, 1'b0, 12'h005, 12'h011, 12'h021, 8'h00, 8'h00, GNT_VGA, 1'b0, 12'h005};
    tv[7] = '{3'b101, 1'b0, 1'b0, 12'h006, 12'h000, 12'h030, 8'h00, 8'h00, GNT_VGA, 1'b0, 12'h006};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      reset_dut();
      {gpu_req, cpu_req, vga_req} = tv[i].req;
      cpu_we = tv[i].cw; gpu_we = tv[i].gw;
      vga_addr = tv[i].va; cpu_addr = tv[i].ca; gpu_addr = tv[i].ga;
      cpu_wdata = tv[i].cd; gpu_wdata = tv[i].gd;
      step();
      check($sformatf("tbl%0d_grant", i), last_g, tv[i].eg);
      check($sformatf("tbl%0d_port", i), last_wa, {tv[i].ewe, tv[i].eaddr});
      drop_all();
      step();
    end
    // CPU write then read back
    reset_dut();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'hA5;
    step(); drop_all(); step();
    cpu_req = 1'b1; cpu_we = 1'b0;
    step(); drop_all(); step();
    check("t1_rdata", cpu_rdata, 8'hA5);
    // CPU and GPU both streaming reads alternate
    reset_dut();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h001;
    gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 12'h002;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_alt", last_g, (i % 2 != 0) ? GNT_GPU : GNT_CPU);
    end
    drop_all(); step();
    // VGA and CPU both streaming: ack masking interleaves them
    reset_dut();
    vga_req = 1'b1; vga_addr = 12'h003;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h004;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_seq", last_g, (i % 2 != 0) ? GNT_CPU : GNT_VGA);
    end
    drop_all(); step();
    // simultaneous requests: VGA, then CPU, then GPU
    reset_dut();
    vga_req = 1'b1; cpu_req = 1'b1; gpu_req = 1'b1; cpu_we = 1'b0; gpu_we = 1'b0;
    step(); check("t4_first", last_g, GNT_VGA);
    vga_req = 1'b0;
    step(); check("t4_second", last_g, GNT_CPU);
    step(); check("t4_third", last_g, GNT_GPU);
    drop_all(); step(); step();
    // reset right after a grant suppresses the ack and restores the pointer
    reset_dut();
    gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 12'h123;
    #2 check("t5_gpu_grant", grant, GNT_GPU);
    rst_n = 1'b0; drop_all();
    @(negedge clk);
    check("t5_no_ack", {vga_ack, cpu_ack, gpu_ack, grant, ram_en}, '0);
    check("t5_data", {gpu_rdata, ram_addr, ram_wdata}, '0);
    rst_n = 1'b1; model_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h124;
    #2 check("t5_cpu_grant", grant, GNT_CPU);
    rst_n = 1'b0; drop_all();
    @(negedge clk);
    check("t5_no_cpu_ack", {cpu_ack, grant}, '0);
    rst_n = 1'b1; model_reset();
    cpu_req = 1'b1; gpu_req = 1'b1;
    step(); check("t5_rr_cpu", last_g, GNT_CPU);
    drop_all(); step(); step();
    // top and bottom of the address space
    reset_dut();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h000; cpu_wdata = 8'h11;
    step(); drop_all(); step();
    gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 12'hFFF; gpu_wdata = 8'h77;
    step(); drop_all(); step();
    gpu_req = 1'b1; gpu_we = 1'b0;
    step(); drop_all(); step();
    check("t6_gpu_fff", gpu_rdata, 8'h77);
    vga_req = 1'b1; vga_addr = 12'h000;
    step(); drop_all(); step();
    check("t6_vga_000", vga_rdata, 8'h11);
    // random traffic, including occasional early request drops
    reset_dut();
    pv = 0; pc = 0; pg = 0;
    for (int c = 0; c < 3000; c++) begin
      if (vga_ack) pv = 0;
      if (cpu_ack) pc = 0;
      if (gpu_ack) pg = 0;
      if (!pv && $urandom_range(0, 2) != 0) begin pv = 1; vga_addr = rnd_addr(); end
      if (!pc && $urandom_range(0, 2) != 0) begin
        pc = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rnd_addr(); cpu_wdata = 8'($urandom);
      end
      if (!pg && $urandom_range(0, 2) != 0) begin
        pg = 1; gpu_we = 1'($urandom_range(0, 1)); gpu_addr = rnd_addr(); gpu_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 63) == 0) pv = 0;
      if ($urandom_range(0, 63) == 0) pc = 0;
      if ($urandom_range(0, 63) == 0) pg = 0;
      vga_req = pv; cpu_req = pc; gpu_req = pg;
      step();
    end
    drop_all(); step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
